// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// two-entry skid buffer. The payload is an opaque WIDTH-bit bundle.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Handshake: a beat moves on an edge where valid and ready are both high;
  // valid never waits on ready, and a held beat stays stable until popped.
  logic             push;
  logic             pop;
  logic             valid_q;
  logic [WIDTH-1:0] main_q;

  assign push      = in_valid & in_ready;
  assign pop       = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;

  if (SKID != 0) begin : g_skid
    state_e           state_q;
    logic [WIDTH-1:0] skid_q;
    logic             ready_q;

    assign in_ready  = ready_q;
    assign occupancy = state_q;

    always_ff @(posedge clk) begin
      if (clr || flush) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              main_q  <= in_data;
              valid_q <= 1'b1;
              state_q <= ST_ONE;
            end
          end
          ST_ONE: begin
            case ({push, pop})
              2'b11: main_q <= in_data;
              2'b10: begin
                skid_q  <= in_data;
                ready_q <= 1'b0;
                state_q <= ST_TWO;
              end
              2'b01: begin
                main_q  <= '0;
                valid_q <= 1'b0;
                state_q <= ST_EMPTY;
              end
              default: ;
            endcase
          end
          ST_TWO: begin
            // in_ready is low here, so only a pop can move the state
            if (pop) begin
              main_q  <= skid_q;
              skid_q  <= '0;
              ready_q <= 1'b1;
              state_q <= ST_ONE;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    assign in_ready  = ~valid_q | out_ready;
    assign occupancy = {1'b0, valid_q};

    always_ff @(posedge clk) begin
      if (clr || flush) begin
        main_q  <= '0;
        valid_q <= 1'b0;
      end else if (push) begin
        main_q  <= in_data;
        valid_q <= 1'b1;
      end else if (pop) begin
        main_q  <= '0;
        valid_q <= 1'b0;
      end
    end
  end

endmodule
